// File: rtl/lc3b_ifetch_unit.sv
// ----------------------------------------------------------------------------
// lc3b_ifetch_unit
// Instruction-fetch stage for the LC-3b pipeline. Owns the fetch PC, keeps at
// most one read outstanding on the instruction-memory port, buffers returned
// words in a QDEPTH-entry queue and hands {inst, npc} to decode over a
// valid/ready handshake. A redirect flushes the queue and restarts fetch.
// A read that is still in flight when a redirect lands cannot be cancelled on
// the memory side. The DRAIN state keeps the old request stable until that
// response arrives, and then drops the response.
//
// Optional feature macro: IFETCH_ALIGN_CHECK_EN
//   defined   : an odd redirect target is fetched from the even address below
//               it. The first entry pushed after that redirect is marked with
//               if_misalign.
//   undefined : bit 0 of the redirect target is cleared and if_misalign is
//               tied low.
// ----------------------------------------------------------------------------
module lc3b_ifetch_unit #(
    parameter int          QDEPTH   = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_address,
    output logic        imem_read,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [15:0] if_inst,
    output logic [15:0] if_npc,
    output logic        if_misalign
);

    localparam int          PW       = $clog2(QDEPTH);
    localparam int          CW       = PW + 1;
    localparam logic [CW-1:0] FULL   = CW'(QDEPTH);
    localparam logic [15:0] START_PC = RESET_PC & 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   drain_addr_q, drain_addr_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_after;

    logic [15:0]   inst_q [QDEPTH];
    logic [15:0]   npc_q  [QDEPTH];

    logic          push;
    logic          pop;
    logic [15:0]   redirect_target;
    logic [15:0]   npc_push;

    // The mask keeps every fetch address even, whatever bit 0 of the target was.
    assign redirect_target = redirect_pc & 16'hFFFE;
    assign npc_push        = pc_q + 16'd2;

    // A flush outranks both a response and a pop in the same cycle.
    assign if_valid = (count_q != '0);
    assign push     = (state_q == REQ) && imem_resp && !redirect_valid;
    assign pop      = if_valid && id_ready && !redirect_valid;

    // Occupancy after this cycle's push/pop. The fetch FSM uses it to decide whether to keep requesting.
    always_comb begin
        count_after = count_q;
        if (push && !pop) begin
            count_after = count_q + CW'(1);
        end else if (!push && pop) begin
            count_after = count_q - CW'(1);
        end
    end

    // Fetch FSM next state, PC update and queue pointer bookkeeping.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_after;

        if (push) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end

        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end else if (count_q < FULL) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (imem_resp) begin
                        state_d = REQ;
                    end else begin
                        drain_addr_d = pc_q;
                        state_d      = DRAIN;
                    end
                end else if (imem_resp) begin
                    pc_d    = npc_push;
                    state_d = (count_after < FULL) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (imem_resp) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State, PC and queue-pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= START_PC;
            drain_addr_q <= START_PC;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

    // Queue storage. The returned word and its fall-through address are written at the tail.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                inst_q[i] <= 16'h0000;
                npc_q[i]  <= 16'h0000;
            end
        end else if (push) begin
            inst_q[tail_q] <= imem_rdata;
            npc_q[tail_q]  <= npc_push;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    logic mis_q [QDEPTH];
    logic pend_q, pend_d;

    // An odd redirect arms the flag. The next word actually pushed consumes it.
    always_comb begin
        pend_d = pend_q;
        if (redirect_valid) begin
            pend_d = redirect_pc[0];
        end else if (push) begin
            pend_d = 1'b0;
        end
    end

    // Pending-misalign register and the per-entry misalign bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                mis_q[i] <= 1'b0;
            end
        end else begin
            pend_q <= pend_d;
            if (push) begin
                mis_q[tail_q] <= pend_q;
            end
        end
    end

    assign if_misalign = if_valid & mis_q[head_q];
`else
    assign if_misalign = 1'b0;
`endif

    // In DRAIN the stale request stays on the bus untouched until the memory answers it.
    assign imem_read    = (state_q != IDLE);
    assign imem_address = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign if_inst      = if_valid ? inst_q[head_q] : 16'h0000;
    assign if_npc       = if_valid ? npc_q[head_q]  : 16'h0000;

endmodule

// File: tb/tb_lc3b_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_lc3b_ifetch_unit
// Scoreboard bench for the fetch unit. Each time the bench redirects or
// restarts fetch, it queues the instruction stream decode should see. A
// negedge monitor pops that queue whenever decode takes an entry. A small
// behavioural memory with programmable latency answers the fetch requests.
// ----------------------------------------------------------------------------
module tb_lc3b_ifetch_unit;

`ifdef IFETCH_ALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] npc;
      logic        mis;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] imem_address;
   logic        imem_read;
   logic        imem_resp;
   logic [15:0] imem_rdata;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [15:0] if_inst;
   logic [15:0] if_npc;
   logic        if_misalign;

   entry_t      expQ[$];
   int          checkCount = 0;
   int          errCount   = 0;
   int          consumed   = 0;
   int          acceptCount = 0;
   logic [15:0] lastAccept = 16'h0000;
   int          memLat;
   logic        memBusy;
   int          memCnt;
   logic [15:0] memAddr;
   int          base;

   lc3b_ifetch_unit #(
      .QDEPTH  (2),
      .RESET_PC(16'h0000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_address  (imem_address),
      .imem_read     (imem_read),
      .imem_resp     (imem_resp),
      .imem_rdata    (imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .id_ready      (id_ready),
      .if_valid      (if_valid),
      .if_inst       (if_inst),
      .if_npc        (if_npc),
      .if_misalign   (if_misalign)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Memory contents: address 0 holds the ADD used in the first-fetch case; elsewhere a scrambled address pattern.
   function automatic logic [15:0] memf(input logic [15:0] a);
      if (a == 16'h0000) return 16'h1261;
      return {a[7:0], a[15:8]} ^ 16'h5A5A ^ a;
   endfunction

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      checkCount++;
      if (got !== want) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // Behavioural instruction memory. It accepts a held read, waits memLat cycles and then pulses imem_resp.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_resp  <= 1'b0;
         imem_rdata <= 16'h0000;
         memBusy    <= 1'b0;
         memCnt     <= 0;
         memAddr    <= 16'h0000;
      end else begin
         imem_resp <= 1'b0;
         if (memBusy) begin
            if (memCnt == 1) begin
               imem_resp  <= 1'b1;
               imem_rdata <= memf(memAddr);
               memBusy    <= 1'b0;
            end else begin
               memCnt <= memCnt - 1;
            end
         end else if (imem_read && !imem_resp) begin
            acceptCount <= acceptCount + 1;
            lastAccept  <= imem_address;
            memAddr     <= imem_address;
            if (memLat <= 1) begin
               imem_resp  <= 1'b1;
               imem_rdata <= memf(imem_address);
            end else begin
               memBusy <= 1'b1;
               memCnt  <= memLat - 1;
            end
         end
      end
   end

   // While the memory is working on a request, the fetch unit must keep the read and address it issued.
   always @(negedge clk) begin
      if (!reset && memBusy) begin
         checkOutput("addr_hold", {15'h0, imem_read, imem_address}, {15'h0, 1'b1, memAddr});
      end
   end

   // Decode-side monitor: each entry decode takes must be the next one on the scoreboard.
   always @(negedge clk) begin
      entry_t e;
      if (!reset && if_valid && id_ready && !redirect_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("extra_entry", 32'(if_npc), 32'hFFFF_FFFF);
         end else begin
            e = expQ.pop_front();
            checkOutput("sb_inst", 32'(if_inst), 32'(e.inst));
            checkOutput("sb_npc",  32'(if_npc),  32'(e.npc));
            checkOutput("sb_mis",  32'(if_misalign), 32'(e.mis));
            consumed++;
         end
      end
   end

   // Queue up the sequential stream decode should see after fetch restarts at 'start'.
   task automatic fillExpected(input logic [15:0] start, input logic firstMis);
      entry_t      e;
      logic [15:0] a;
      expQ.delete();
      a = start & 16'hFFFE;
      for (int i = 0; i < 16; i++) begin
         e.inst = memf(a);
         e.npc  = a + 16'd2;
         e.mis  = (i == 0) ? firstMis : 1'b0;
         expQ.push_back(e);
         a = a + 16'd2;
      end
   endtask

   // Apply a one-cycle redirect, starting just after a rising edge. The head entry must be gone in the following cycle.
   task automatic applyStimulus(input logic [15:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      fillExpected(target, MIS_EN & target[0]);
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      @(negedge clk);
      checkOutput("redir_flush", 32'(if_valid), 32'd0);
   endtask

   // Wait for the memory's next accept. Optionally check the address it accepted.
   task automatic waitAccept(input string tag, input logic [15:0] addr, input int budget, input bit checkAddr);
      int startCount;
      int n;
      startCount = acceptCount;
      n = 0;
      while (acceptCount == startCount && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (acceptCount == startCount) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
      else if (checkAddr) checkOutput(tag, 32'(lastAccept), 32'(addr));
   endtask

   // Wait until decode has taken n more entries from the scoreboard.
   task automatic waitConsumed(input string tag, input int n, input int budget);
      int target;
      int k;
      target = consumed + n;
      k = 0;
      while (consumed < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      checkOutput(tag, 32'(consumed >= target), 32'd1);
   endtask

   // Global time limit so the bench always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence. Inputs change just after a rising edge; outputs are sampled on the falling edge.
   initial begin
      reset          = 1'b0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      memLat         = 1;
      #1 reset = 1'b1;

      // Reset values.
      @(negedge clk);
      checkOutput("rst_read",  32'(imem_read),    32'd0);
      checkOutput("rst_addr",  32'(imem_address), 32'h0000);
      checkOutput("rst_valid", 32'(if_valid),     32'd0);
      checkOutput("rst_inst",  32'(if_inst),      32'd0);
      checkOutput("rst_npc",   32'(if_npc),       32'd0);
      checkOutput("rst_mis",   32'(if_misalign),  32'd0);
      base = acceptCount;
      @(posedge clk);
      #1 reset = 1'b0;

      // First fetch: request in cycle 1, head entry visible in cycle 3.
      @(negedge clk);
      checkOutput("c0_read", 32'(imem_read), 32'd0);
      @(negedge clk);
      checkOutput("c1_read", 32'(imem_read), 32'd1);
      checkOutput("c1_addr", 32'(imem_address), 32'h0000);
      @(negedge clk);
      checkOutput("c2_valid", 32'(if_valid), 32'd0);
      @(negedge clk);
      checkOutput("c3_valid", 32'(if_valid), 32'd1);
      checkOutput("c3_inst",  32'(if_inst),  32'h1261);
      checkOutput("c3_npc",   32'(if_npc),   32'h0002);

      // Decode stalled: exactly two words are buffered and fetch goes quiet.
      repeat (7) @(negedge clk);
      checkOutput("stall_read",    32'(imem_read), 32'd0);
      checkOutput("stall_valid",   32'(if_valid),  32'd1);
      checkOutput("stall_inst",    32'(if_inst),   32'h1261);
      checkOutput("stall_fetches", 32'(acceptCount - base), 32'd2);

      // Release the stall: entries drain in order and fetch resumes at 0x0004.
      @(posedge clk);
      #1 fillExpected(16'h0000, 1'b0);
      id_ready = 1'b1;
      waitAccept("resume_addr", 16'h0004, 40, 1'b1);
      waitConsumed("resume_order", 3, 60);

      // Restart with a slow memory. A redirect lands while the read of 0x0004 is in flight.
      @(posedge clk);
      #1 reset = 1'b1;
      memLat = 4;
      expQ.delete();
      @(posedge clk);
      #1 fillExpected(16'h0000, 1'b0);
      reset = 1'b0;
      waitAccept("d_acc0", 16'h0000, 40, 1'b1);
      waitAccept("d_acc2", 16'h0002, 40, 1'b1);
      waitAccept("d_acc4", 16'h0004, 40, 1'b1);
      @(posedge clk);
      #1 applyStimulus(16'h3000);
      checkOutput("drain_read", 32'(imem_read),    32'd1);
      checkOutput("drain_addr", 32'(imem_address), 32'h0004);
      @(negedge clk);
      checkOutput("drain_addr2",  32'(imem_address), 32'h0004);
      checkOutput("drain_valid",  32'(if_valid),     32'd0);
      waitAccept("drain_next", 16'h3000, 40, 1'b1);
      waitConsumed("drain_stream", 2, 80);

      // Redirect in the same cycle as a response: the word is dropped and there is no drain.
      memLat = 2;
      waitAccept("sync_a", 16'h0000, 40, 1'b0);
      waitAccept("sync_b", 16'h0000, 40, 1'b0);
      @(posedge clk);
      #1 applyStimulus(16'h3000);
      checkOutput("nodrain_read", 32'(imem_read),    32'd1);
      checkOutput("nodrain_addr", 32'(imem_address), 32'h3000);
      waitAccept("nodrain_acc", 16'h3000, 40, 1'b1);
      waitConsumed("nodrain_stream", 2, 80);

      // Redirect to the last word of the address space: npc wraps to 0x0000.
      waitAccept("wrap_sync", 16'h0000, 40, 1'b0);
      @(posedge clk);
      #1 applyStimulus(16'hFFFE);
      waitAccept("wrap_acc0", 16'hFFFE, 40, 1'b1);
      waitAccept("wrap_acc1", 16'h0000, 40, 1'b1);
      waitConsumed("wrap_stream", 2, 80);

      // Odd redirect target: the even word is fetched, and the misalign flag depends on the build.
      waitAccept("mis_sync", 16'h0000, 40, 1'b0);
      @(posedge clk);
      #1 applyStimulus(16'h4001);
      waitAccept("mis_acc", 16'h4000, 40, 1'b1);
      waitConsumed("mis_stream", 2, 80);

      // Reset asserted mid-DRAIN clears every output at once.
      memLat = 6;
      waitAccept("rd_sync_a", 16'h0000, 60, 1'b0);
      waitAccept("rd_sync_b", 16'h0000, 60, 1'b0);
      @(posedge clk);
      #1 applyStimulus(16'h6000);
      checkOutput("rd_drain_addr", 32'(imem_address), 32'(lastAccept));
      #2 reset = 1'b1;
      #1;
      checkOutput("rd_read",  32'(imem_read),    32'd0);
      checkOutput("rd_addr",  32'(imem_address), 32'h0000);
      checkOutput("rd_valid", 32'(if_valid),     32'd0);
      checkOutput("rd_inst",  32'(if_inst),      32'd0);
      checkOutput("rd_npc",   32'(if_npc),       32'd0);
      checkOutput("rd_mis",   32'(if_misalign),  32'd0);
      expQ.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
